// File: rtl/ip_hdr_chksum_ingress.sv
// Ingress formatter: forwards every MAC rx beat to the data FIFO and the IPv4 header lines to the checksum engine.
// Optional statistics counters are built when IP_INGRESS_STATS_EN is defined.
`timescale 1ns/1ps

module ip_hdr_chksum_ingress #(
  parameter  int DATA_WIDTH     = 256,
  parameter  int DATA_BYTES     = DATA_WIDTH / 8,
  parameter  int KEEP_WIDTH     = DATA_BYTES,
  parameter  int PADBYTES_WIDTH = $clog2(DATA_BYTES),
  parameter  int CHKSUM_OFFSET  = 10,
  parameter  int HDR_CNT_W      = $clog2(60 / DATA_BYTES + 2),
  parameter  int TS_WIDTH       = 64,
  localparam int FIFO_WIDTH     = DATA_WIDTH + PADBYTES_WIDTH + 1 + TS_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      src_in_val,
  input  logic [TS_WIDTH-1:0]       src_in_timestamp,
  output logic                      in_src_rdy,
  input  logic [DATA_WIDTH-1:0]     src_in_data,
  input  logic                      src_in_last,
  input  logic [PADBYTES_WIDTH-1:0] src_in_padbytes,
  output logic                      chksum_cmd_val,
  output logic                      chksum_cmd_enable,
  output logic [7:0]                chksum_cmd_start,
  output logic [7:0]                chksum_cmd_offset,
  output logic [15:0]               chksum_cmd_init,
  input  logic                      chksum_cmd_rdy,
  output logic                      chksum_req_val,
  output logic [DATA_WIDTH-1:0]     chksum_req_data,
  output logic [KEEP_WIDTH-1:0]     chksum_req_keep,
  output logic                      chksum_req_last,
  input  logic                      chksum_req_rdy,
  output logic                      fifo_wr_req,
  output logic [FIFO_WIDTH-1:0]     fifo_wr_data,
  input  logic                      fifo_full,
  output logic                      hdr_err,
  output logic                      trunc_err
`ifdef IP_INGRESS_STATS_EN
  ,
  output logic [31:0]               pkt_cnt,
  output logic [31:0]               hdr_err_cnt,
  output logic [31:0]               trunc_cnt
`endif
);

  localparam logic [KEEP_WIDTH-1:0] KEEP_ONES = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_BODY = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [HDR_CNT_W-1:0]  r_cnt;
  logic [HDR_CNT_W-1:0]  w_cnt_next;
  logic [7:0]            r_tail;
  logic [7:0]            w_tail_next;

  logic                  r_req_val;
  logic [DATA_WIDTH-1:0] r_req_data;
  logic [KEEP_WIDTH-1:0] r_req_keep;
  logic                  r_req_last;

  logic                  w_slot_free;
  logic                  w_in_rdy;
  logic                  w_cmd_val;
  logic                  w_accept;
  logic                  w_load;
  logic [KEEP_WIDTH-1:0] w_load_keep;
  logic                  w_load_last;
  logic                  w_hdr_err;
  logic                  w_trunc_err;

  logic [3:0]            w_ver;
  logic [3:0]            w_ihl;
  logic                  w_ok;
  logic [7:0]            w_hdr_bytes;
  logic [7:0]            w_hdr_lines;
  logic [7:0]            w_tail;
  logic [KEEP_WIDTH-1:0] w_pad_keep;

  // Keep mask whose leading 'tail' bytes are valid (MSB is byte 0).
  function automatic logic [KEEP_WIDTH-1:0] f_keep_tail(input logic [7:0] tail);
    return KEEP_ONES << (8'(DATA_BYTES) - tail);
  endfunction

  assign w_ver       = src_in_data[DATA_WIDTH-1 -: 4];
  assign w_ihl       = src_in_data[DATA_WIDTH-5 -: 4];
  assign w_ok        = (w_ver == 4'd4) && (w_ihl >= 4'd5);
  assign w_hdr_bytes = {2'b00, w_ihl, 2'b00};
  assign w_hdr_lines = (w_hdr_bytes + 8'(DATA_BYTES - 1)) / 8'(DATA_BYTES);
  assign w_tail      = w_hdr_bytes - 8'((w_hdr_lines - 8'd1) * 8'(DATA_BYTES));
  assign w_pad_keep  = KEEP_ONES << src_in_padbytes;

  assign w_slot_free = ~r_req_val | chksum_req_rdy;

  // Readiness never depends on src_in_val, and the command valid never on chksum_cmd_rdy.
  always_comb begin
    w_in_rdy  = 1'b0;
    w_cmd_val = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_IDLE: begin
          w_cmd_val = src_in_val & ~fifo_full & w_slot_free;
          w_in_rdy  = chksum_cmd_rdy & ~fifo_full & w_slot_free;
        end
        S_HDR:   w_in_rdy = ~fifo_full & w_slot_free;
        S_BODY:  w_in_rdy = ~fifo_full;
        default: w_in_rdy = 1'b0;
      endcase
    end
  end

  assign w_accept = src_in_val & w_in_rdy;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_tail_next  = r_tail;
    w_load       = 1'b0;
    w_load_keep  = KEEP_ONES;
    w_load_last  = 1'b0;
    w_hdr_err    = 1'b0;
    w_trunc_err  = 1'b0;
    if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          w_tail_next = w_tail;
          if (w_ok) begin
            w_load      = 1'b1;
            w_load_last = (w_hdr_lines == 8'd1) | src_in_last;
            if (w_hdr_lines == 8'd1) begin
              w_load_keep = f_keep_tail(w_tail);
            end else if (src_in_last) begin
              w_load_keep = w_pad_keep;
              w_trunc_err = 1'b1;
            end
          end else begin
            w_hdr_err = 1'b1;
          end
          if (src_in_last) begin
            w_state_next = S_IDLE;
          end else if (w_ok && (w_hdr_lines > 8'd1)) begin
            w_state_next = S_HDR;
            w_cnt_next   = HDR_CNT_W'(w_hdr_lines - 8'd2);
          end else begin
            w_state_next = S_BODY;
          end
        end
        S_HDR: begin
          w_load = 1'b1;
          if (r_cnt == '0) begin
            w_load_last  = 1'b1;
            w_load_keep  = f_keep_tail(r_tail);
            w_state_next = src_in_last ? S_IDLE : S_BODY;
          end else if (src_in_last) begin
            w_load_last  = 1'b1;
            w_load_keep  = w_pad_keep;
            w_trunc_err  = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_cnt_next = r_cnt - 1'b1;
          end
        end
        S_BODY: begin
          if (src_in_last) begin
            w_state_next = S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tail  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_tail  <= w_tail_next;
    end
  end

  // Loads happen only when the slot is free, so held data stays stable under back-pressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req_val  <= 1'b0;
      r_req_data <= '0;
      r_req_keep <= '0;
      r_req_last <= 1'b0;
    end else if (w_load) begin
      r_req_val  <= 1'b1;
      r_req_data <= src_in_data;
      r_req_keep <= w_load_keep;
      r_req_last <= w_load_last;
    end else if (chksum_req_rdy) begin
      r_req_val  <= 1'b0;
    end
  end

  assign in_src_rdy        = w_in_rdy;
  assign chksum_cmd_val    = w_cmd_val;
  assign chksum_cmd_enable = w_ok;
  assign chksum_cmd_start  = 8'd0;
  assign chksum_cmd_offset = 8'(CHKSUM_OFFSET);
  assign chksum_cmd_init   = 16'd0;
  assign chksum_req_val    = r_req_val;
  assign chksum_req_data   = r_req_data;
  assign chksum_req_keep   = r_req_keep;
  assign chksum_req_last   = r_req_last;
  assign fifo_wr_req       = w_accept;
  assign fifo_wr_data      = {src_in_data, src_in_padbytes, src_in_last, src_in_timestamp};
  assign hdr_err           = w_hdr_err;
  assign trunc_err         = w_trunc_err;

`ifdef IP_INGRESS_STATS_EN
  logic [2:0] w_stat_evt;
  assign w_stat_evt = {w_trunc_err, w_hdr_err, w_accept & src_in_last};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_stat
      logic [31:0] r_cnt_val;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_cnt_val <= '0;
        end else if (w_stat_evt[gi] && (r_cnt_val != 32'hFFFF_FFFF)) begin
          r_cnt_val <= r_cnt_val + 32'd1;
        end
      end
    end
  endgenerate

  assign pkt_cnt     = g_stat[0].r_cnt_val;
  assign hdr_err_cnt = g_stat[1].r_cnt_val;
  assign trunc_cnt   = g_stat[2].r_cnt_val;
`endif

endmodule

// File: tb/tb_ip_hdr_chksum_ingress.sv
// Randomised bench for ip_hdr_chksum_ingress at 64-bit width against a packet-level reference model.
`timescale 1ns/1ps

module tb_ip_hdr_chksum_ingress;
  localparam int DW = 64;
  localparam int DB = DW / 8;
  localparam int KW = DB;
  localparam int PW = 3;
  localparam int TW = 16;
  localparam int FW = DW + PW + 1 + TW;

  logic          clk;
  logic          rst_n;
  logic          src_in_val;
  logic [TW-1:0] src_in_timestamp;
  logic          in_src_rdy;
  logic [DW-1:0] src_in_data;
  logic          src_in_last;
  logic [PW-1:0] src_in_padbytes;
  logic          chksum_cmd_val;
  logic          chksum_cmd_enable;
  logic [7:0]    chksum_cmd_start;
  logic [7:0]    chksum_cmd_offset;
  logic [15:0]   chksum_cmd_init;
  logic          chksum_cmd_rdy;
  logic          chksum_req_val;
  logic [DW-1:0] chksum_req_data;
  logic [KW-1:0] chksum_req_keep;
  logic          chksum_req_last;
  logic          chksum_req_rdy;
  logic          fifo_wr_req;
  logic [FW-1:0] fifo_wr_data;
  logic          fifo_full;
  logic          hdr_err;
  logic          trunc_err;

  ip_hdr_chksum_ingress #(.DATA_WIDTH(DW), .TS_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_in_val(src_in_val), .src_in_timestamp(src_in_timestamp), .in_src_rdy(in_src_rdy),
    .src_in_data(src_in_data), .src_in_last(src_in_last), .src_in_padbytes(src_in_padbytes),
    .chksum_cmd_val(chksum_cmd_val), .chksum_cmd_enable(chksum_cmd_enable),
    .chksum_cmd_start(chksum_cmd_start), .chksum_cmd_offset(chksum_cmd_offset),
    .chksum_cmd_init(chksum_cmd_init), .chksum_cmd_rdy(chksum_cmd_rdy),
    .chksum_req_val(chksum_req_val), .chksum_req_data(chksum_req_data),
    .chksum_req_keep(chksum_req_keep), .chksum_req_last(chksum_req_last),
    .chksum_req_rdy(chksum_req_rdy),
    .fifo_wr_req(fifo_wr_req), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
    .hdr_err(hdr_err), .trunc_err(trunc_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pkt_done = 0;
  bit mon_en = 0;
  bit stall_en = 0;

  // Driver-side description of the beat currently presented.
  bit drv_first = 0, drv_bad = 0, drv_in_hdr = 0, drv_trunc = 0;

  // Reference model outputs.
  logic [FW-1:0] exp_fifo [$];
  logic          exp_cmd [$];
  logic [DW-1:0] exp_rd [$];
  logic [KW-1:0] exp_rk [$];
  logic          exp_rl [$];
  int exp_hdr_n = 0, exp_trunc_n = 0, seen_hdr_n = 0, seen_trunc_n = 0;

  // Observed request stream and write cycles, for literal checks.
  logic [KW-1:0] obs_keep [$];
  logic          obs_last [$];
  int            wr_cyc [$];

  logic          hold = 0;
  logic [DW-1:0] hold_data;
  logic [KW-1:0] hold_keep;
  logic          hold_last;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with no expectation (cycle %0d)", name, cyc);
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Number of leading valid bytes -> keep mask (MSB is byte 0).
  function automatic logic [KW-1:0] mk_keep(input int nbytes);
    logic [KW-1:0] k;
    k = '0;
    for (int b = 0; b < KW; b++) if (b < nbytes) k[KW-1-b] = 1'b1;
    return k;
  endfunction

  // Monitor: sampled at negedge, describing what completes at the next posedge.
  always @(negedge clk) begin
    logic slot;
    logic exp_rdy;
    if (mon_en && rst_n) begin
      slot = ~chksum_req_val | chksum_req_rdy;
      chk("cmd_val", chksum_cmd_val, drv_first & src_in_val & ~fifo_full & slot);
      if (src_in_val) begin
        if (drv_first)       exp_rdy = chksum_cmd_rdy & ~fifo_full & slot;
        else if (drv_in_hdr) exp_rdy = ~fifo_full & slot;
        else                 exp_rdy = ~fifo_full;
        chk("in_src_rdy", in_src_rdy, exp_rdy);
      end
      chk("fifo_wr_req", fifo_wr_req, src_in_val & in_src_rdy);
      if (fifo_wr_req) begin
        wr_cyc.push_back(cyc);
        if (exp_fifo.size() == 0) fail_evt("fifo_wr");
        else chk("fifo_wr_data", fifo_wr_data, exp_fifo.pop_front());
        if (src_in_last) begin
          pkt_done++;
          $display("pkt %0d: last beat written at cycle %0d", pkt_done, cyc);
        end
      end
      chk("hdr_err", hdr_err, fifo_wr_req & drv_first & drv_bad);
      chk("trunc_err", trunc_err, fifo_wr_req & drv_trunc);
      if (hdr_err) seen_hdr_n++;
      if (trunc_err) seen_trunc_n++;
      if (chksum_cmd_val & chksum_cmd_rdy) begin
        if (exp_cmd.size() == 0) fail_evt("cmd");
        else chk("cmd_enable", chksum_cmd_enable, exp_cmd.pop_front());
        chk("cmd_const", {chksum_cmd_start, chksum_cmd_offset, chksum_cmd_init}, {8'd0, 8'd10, 16'd0});
      end
      if (hold)
        chk("req_hold", {chksum_req_val, chksum_req_last, chksum_req_keep, chksum_req_data},
            {1'b1, hold_last, hold_keep, hold_data});
      hold      = chksum_req_val & ~chksum_req_rdy;
      hold_data = chksum_req_data;
      hold_keep = chksum_req_keep;
      hold_last = chksum_req_last;
      if (chksum_req_val & chksum_req_rdy) begin
        obs_keep.push_back(chksum_req_keep);
        obs_last.push_back(chksum_req_last);
        if (exp_rd.size() == 0) fail_evt("req");
        else begin
          chk("req_data", chksum_req_data, exp_rd.pop_front());
          chk("req_keep", chksum_req_keep, exp_rk.pop_front());
          chk("req_last", chksum_req_last, exp_rl.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_en) begin
        chksum_cmd_rdy = ($urandom % 4) != 0;
        chksum_req_rdy = ($urandom % 3) != 0;
        fifo_full      = ($urandom % 5) == 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    errors++;
    finish_sim();
  end

  task automatic wait_accept();
    int w;
    w = 0;
    forever begin
      @(negedge clk);
      if (in_src_rdy) break;
      w++;
      if (w > 500) begin
        fail_evt("accept_timeout");
        finish_sim();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_fifo.size() != 0 || exp_cmd.size() != 0 || exp_rd.size() != 0) begin
      @(posedge clk);
      w++;
      if (w > 2000) begin
        fail_evt("drain_timeout");
        finish_sim();
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Builds the expected FIFO, command and request streams for one packet, then drives it.
  task automatic send_pkt(input logic [3:0] ver, input logic [3:0] ihl, input int len,
                          input logic [PW-1:0] pad, input int maxgap);
    logic [DW-1:0] dat [$];
    logic [TW-1:0] ts [$];
    bit ok;
    int hb, hl, n, nb;
    ok = (ver == 4'd4) && (ihl >= 4'd5);
    hb = int'(ihl) * 4;
    hl = (hb + DB - 1) / DB;
    for (int i = 0; i < len; i++) begin
      logic [DW-1:0] w;
      logic [TW-1:0] t;
      w = {$urandom, $urandom};
      if (i == 0) w[DW-1 -: 8] = {ver, ihl};
      t = TW'($urandom);
      dat.push_back(w);
      ts.push_back(t);
      exp_fifo.push_back({w, (i == len - 1) ? pad : PW'(0), (i == len - 1), t});
    end
    exp_cmd.push_back(ok);
    if (ok) begin
      n = (len < hl) ? len : hl;
      for (int i = 0; i < n; i++) begin
        if (i == hl - 1)       nb = hb - (hl - 1) * DB;
        else if (i == len - 1) nb = DB - int'(pad);
        else                   nb = DB;
        exp_rd.push_back(dat[i]);
        exp_rk.push_back(mk_keep(nb));
        exp_rl.push_back(i == n - 1);
      end
      if (len < hl) exp_trunc_n++;
    end else begin
      exp_hdr_n++;
    end
    for (int i = 0; i < len; i++) begin
      src_in_val       = 1'b1;
      src_in_data      = dat[i];
      src_in_timestamp = ts[i];
      src_in_last      = (i == len - 1);
      src_in_padbytes  = (i == len - 1) ? pad : PW'(0);
      drv_first        = (i == 0);
      drv_bad          = !ok;
      drv_in_hdr       = ok && (i < hl);
      drv_trunc        = ok && (len < hl) && (i == len - 1);
      wait_accept();
      if (maxgap > 0 && i < len - 1) begin
        src_in_val = 1'b0;
        repeat ($urandom_range(0, maxgap)) @(posedge clk);
        #1;
      end
    end
    src_in_val = 1'b0;
    drv_trunc  = 1'b0;
  endtask

  task automatic clear_obs();
    obs_keep.delete();
    obs_last.delete();
    wr_cyc.delete();
  endtask

  initial begin
    int t0, h0;
    rst_n = 1'b0;
    src_in_val = 1'b0;
    src_in_data = '0;
    src_in_timestamp = '0;
    src_in_last = 1'b0;
    src_in_padbytes = '0;
    chksum_cmd_rdy = 1'b1;
    chksum_req_rdy = 1'b1;
    fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_val", chksum_req_val, 1'b0);
    chk("rst_cmd_val", chksum_cmd_val, 1'b0);
    chk("rst_fifo_wr", fifo_wr_req, 1'b0);
    chk("rst_errs", {hdr_err, trunc_err}, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // IHL=5 in a 4-beat packet: 20 bytes -> 3 lines, final keep F0, no bubbles.
    clear_obs();
    send_pkt(4'd4, 4'd5, 4, 3'd0, 0);
    wait_drain();
    chk("A_nreq", obs_keep.size(), 3);
    chk("A_keep", {obs_keep[0], obs_keep[1], obs_keep[2]}, 24'hFFFF_F0);
    chk("A_last", {obs_last[0], obs_last[1], obs_last[2]}, 3'b001);
    chk("A_nobubble", wr_cyc[3] - wr_cyc[0], 3);

    // Two back-to-back packets: beats must be written on consecutive cycles.
    clear_obs();
    send_pkt(4'd4, 4'd5, 3, 3'd0, 0);
    send_pkt(4'd4, 4'd5, 3, 3'd0, 0);
    wait_drain();
    chk("B2B_nobubble", wr_cyc[5] - wr_cyc[0], 5);
    chk("B2B_keep", {obs_keep[2], obs_keep[5]}, 16'hF0F0);

    // IHL=6 truncated after 2 beats with padbytes=5: keep FF then E0.
    clear_obs();
    t0 = seen_trunc_n;
    send_pkt(4'd4, 4'd6, 2, 3'd5, 0);
    wait_drain();
    chk("T_keep", {obs_keep[0], obs_keep[1]}, 16'hFFE0);
    chk("T_last", {obs_last[0], obs_last[1]}, 2'b01);
    chk("T_pulse", seen_trunc_n - t0, 1);

    // Version 6 and IHL 3: no request beats, one hdr_err pulse each.
    clear_obs();
    h0 = seen_hdr_n;
    send_pkt(4'd6, 4'd5, 3, 3'd0, 0);
    send_pkt(4'd4, 4'd3, 2, 3'd1, 0);
    wait_drain();
    chk("BAD_nreq", obs_keep.size(), 0);
    chk("BAD_pulses", seen_hdr_n - h0, 2);
    chk("BAD_nwr", wr_cyc.size(), 5);

    // IHL=15 with request back-pressure mid-header, then FIFO full in the body.
    clear_obs();
    fork
      send_pkt(4'd4, 4'd15, 11, 3'd2, 0);
      begin
        repeat (3) @(posedge clk);
        #1 chksum_req_rdy = 1'b0;
        repeat (5) @(posedge clk);
        #1 chksum_req_rdy = 1'b1;
        repeat (6) @(posedge clk);
        #1 fifo_full = 1'b1;
        repeat (4) @(posedge clk);
        #1 fifo_full = 1'b0;
      end
    join
    wait_drain();
    chk("H_nreq", obs_keep.size(), 8);
    chk("H_lastkeep", obs_keep[7], 8'hF0);
    chk("H_midkeep", obs_keep[6], 8'hFF);
    chk("H_last", obs_last[7], 1'b1);

    // Single-beat packet, header cut short on the first beat: keep = ones << 2.
    clear_obs();
    send_pkt(4'd4, 4'd5, 1, 3'd2, 0);
    wait_drain();
    chk("S_keep", obs_keep[0], 8'hFC);

    // Randomised traffic with random back-pressure.
    stall_en = 1'b1;
    for (int p = 0; p < 60; p++) begin
      logic [3:0] v, ih;
      v  = (($urandom % 10) == 0) ? 4'($urandom) : 4'd4;
      ih = (($urandom % 8) == 0) ? 4'($urandom % 5) : 4'($urandom_range(5, 15));
      send_pkt(v, ih, $urandom_range(1, 12), PW'($urandom), (($urandom % 2) != 0) ? 2 : 0);
    end
    stall_en = 1'b0;
    @(posedge clk);
    #1;
    chksum_cmd_rdy = 1'b1;
    chksum_req_rdy = 1'b1;
    fifo_full = 1'b0;
    wait_drain();
    chk("hdr_err_total", seen_hdr_n, exp_hdr_n);
    chk("trunc_total", seen_trunc_n, exp_trunc_n);

    // Reset in the middle of a header: valids drop, next packet starts fresh.
    mon_en = 1'b0;
    src_in_val = 1'b1;
    src_in_last = 1'b0;
    src_in_padbytes = '0;
    src_in_data = {4'd4, 4'd15, 56'h0};
    for (int i = 0; i < 3; i++) wait_accept();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_req_val", chksum_req_val, 1'b0);
    chk("mrst_cmd_val", chksum_cmd_val, 1'b0);
    chk("mrst_fifo_wr", fifo_wr_req, 1'b0);
    chk("mrst_errs", {hdr_err, trunc_err}, 2'b00);
    @(posedge clk);
    #1;
    src_in_val = 1'b0;
    rst_n = 1'b1;
    exp_fifo.delete();
    exp_cmd.delete();
    exp_rd.delete();
    exp_rk.delete();
    exp_rl.delete();
    hold = 1'b0;
    mon_en = 1'b1;
    clear_obs();
    send_pkt(4'd4, 4'd7, 4, 3'd1, 0);
    wait_drain();
    chk("R_nreq", obs_keep.size(), 4);
    chk("R_lastkeep", obs_keep[3], 8'hF0);
    chk("R_drained", exp_fifo.size() + exp_cmd.size() + exp_rd.size(), 0);
    finish_sim();
  end

endmodule
